// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage in-order pipeline.
// It resolves three sources of disturbance to the front end:
//   - taken branch/jump in EX: squash IF/ID and ID/EX, keep fetching;
//   - load-use hazard: hold PC and IF/ID, inject one bubble into ID/EX;
//   - multi-cycle mult/div: freeze PC, IF/ID and ID/EX while EX is occupied.
// It also keeps a saturating count of stalled cycles.
// dbg_state exposes the FSM state (0=RST_HOLD, 1=RUN, 2=MD_WAIT).
module pipe_stall_ctrl #(
  parameter int MULT_CYC = 4,
  parameter int DIV_CYC  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        id_md_start,
  input  logic        id_md_div,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        md_busy,
  output logic [15:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_md_cnt;
  logic [15:0] r_stall_cnt;

  logic        w_hz;
  logic [5:0]  w_md_load;
  logic        w_md_go;

  // Load-use hazard: EX load writes a register that ID reads (r0 never hazards).
  assign w_hz = idex_mem_read & (idex_rt != 5'd0) &
                ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  // The entry cycle counts as one EX cycle, so MD_WAIT lasts N-1 cycles.
  assign w_md_load = id_md_div ? 6'(DIV_CYC - 1) : 6'(MULT_CYC - 1);

  // A mult/div is only accepted in RUN when no branch squash or hazard wins.
  assign w_md_go = (r_state == RUN) & ~branch_taken & ~w_hz & id_md_start;

  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

  // Combinational pipeline-register controls decoded from state and hazards.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_busy    = 1'b0;
    case (r_state)
      RST_HOLD: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      RUN: begin
        if (branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_hz) begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          idex_en = 1'b1;
        end
      end
      MD_WAIT: begin
        md_busy = 1'b1;
      end
      default: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
    endcase
  end

  // FSM, mult/div occupancy counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RST_HOLD;
      r_md_cnt    <= 6'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (!pc_en && (r_state != RST_HOLD) && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      case (r_state)
        RST_HOLD: begin
          r_state <= RUN;
        end
        RUN: begin
          if (w_md_go) begin
            r_state  <= MD_WAIT;
            r_md_cnt <= w_md_load;
          end
        end
        MD_WAIT: begin
          r_md_cnt <= r_md_cnt - 6'd1;
          if (r_md_cnt == 6'd1) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state  <= RST_HOLD;
          r_md_cnt <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a vector table for single-cycle RUN
// behaviour plus hand-written sequences for mult, divide, reset mid-divide
// and stall counter saturation.
module tb_pipe_stall_ctrl;

  localparam logic [1:0] ST_RST = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_MD  = 2'd2;

  // Output bundle order: {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, md_busy}
  localparam logic [5:0] O_RST  = 6'b000110;
  localparam logic [5:0] O_RUN  = 6'b111000;
  localparam logic [5:0] O_HZ   = 6'b001010;
  localparam logic [5:0] O_BR   = 6'b111110;
  localparam logic [5:0] O_MD   = 6'b000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        ifid_uses_rt;
  logic        id_md_start;
  logic        id_md_div;
  logic        branch_taken;
  logic        pc_en, ifid_en, idex_en, ifid_flush, idex_flush, md_busy;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;
  logic [5:0]  outs;

  assign outs = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, md_busy};

  pipe_stall_ctrl #(.MULT_CYC(4), .DIV_CYC(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .id_md_start   (id_md_start),
    .id_md_div     (id_md_div),
    .branch_taken  (branch_taken),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .md_busy       (md_busy),
    .stall_cnt     (stall_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic use_rt, input logic md,
                       input logic div, input logic br);
    idex_mem_read = mr;
    idex_rt       = ex_rt;
    ifid_rs       = rs;
    ifid_rt       = rt;
    ifid_uses_rt  = use_rt;
    id_md_start   = md;
    id_md_div     = div;
    branch_taken  = br;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        mr;
    logic [4:0]  ex_rt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rt;
    logic        md;
    logic        br;
    logic [5:0]  exp_o;
    logic [15:0] exp_s;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] w_exp;

  initial begin
    // exp_s is the stall count visible during the vector, before its edge.
    vecs[0] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, O_RUN, 16'd0};
    vecs[1] = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b0, O_HZ,  16'd0};
    vecs[2] = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, O_RUN, 16'd1};
    vecs[3] = '{1'b1, 5'd7,  5'd3, 5'd7,  1'b0, 1'b0, 1'b0, O_RUN, 16'd1};
    vecs[4] = '{1'b1, 5'd7,  5'd3, 5'd7,  1'b1, 1'b0, 1'b0, O_HZ,  16'd1};
    vecs[5] = '{1'b0, 5'd7,  5'd7, 5'd7,  1'b1, 1'b0, 1'b0, O_RUN, 16'd2};
    vecs[6] = '{1'b1, 5'd9,  5'd9, 5'd0,  1'b0, 1'b1, 1'b1, O_BR,  16'd2};
    vecs[7] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, O_RUN, 16'd2};
    vecs[8] = '{1'b1, 5'd31, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, O_HZ,  16'd2};
    vecs[9] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, O_RUN, 16'd3};

    // Reset held for two edges, then one RST_HOLD cycle after release.
    rst = 1'b0;
    idle();
    tick();
    tick();
    #3;
    chk("rst_outs",  {10'd0, outs}, {10'd0, O_RST});
    chk("rst_state", {14'd0, dbg_state}, {14'd0, ST_RST});
    chk("rst_stall", stall_cnt, 16'd0);
    rst = 1'b1;
    #1;
    chk("rel_cyc0_outs", {10'd0, outs}, {10'd0, O_RST});
    tick();

    // Table-driven single-cycle behaviour in RUN.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt, vecs[i].use_rt,
            vecs[i].md, 1'b0, vecs[i].br);
      #3;
      chk($sformatf("vec%0d_outs", i), {10'd0, outs}, {10'd0, vecs[i].exp_o});
      chk($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].exp_s);
      chk($sformatf("vec%0d_state", i), {14'd0, dbg_state}, {14'd0, ST_RUN});
      tick();
    end

    // Multiply: 3 MD_WAIT cycles after the entry cycle.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #3;
    chk("mul_entry_outs", {10'd0, outs}, {10'd0, O_RUN});
    tick();
    for (int k = 0; k < 3; k++) exp_q.push_back(16'd1);
    exp_q.push_back(16'd0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      #3;
      w_exp = exp_q.pop_front();
      chk($sformatf("mul_busy%0d", k), {15'd0, md_busy}, w_exp);
      chk($sformatf("mul_pc%0d", k), {15'd0, pc_en}, {15'd0, ~w_exp[0]});
      if (k == 4) begin
        chk("mul_done_outs", {10'd0, outs}, {10'd0, O_RUN});
        chk("mul_done_stall", stall_cnt, 16'd6);
      end
      tick();
    end

    // Divide: 31 MD_WAIT cycles, branch/hazard/md_start pulses ignored.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    chk("div_entry_outs", {10'd0, outs}, {10'd0, O_RUN});
    tick();
    for (int k = 0; k < 31; k++) exp_q.push_back({10'd0, O_MD});
    exp_q.push_back({10'd0, O_RUN});
    for (int k = 1; k <= 32; k++) begin
      idle();
      if (k == 2)  branch_taken = 1'b1;
      if (k == 5)  drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 10) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 32) idle();
      #3;
      w_exp = exp_q.pop_front();
      chk($sformatf("div_cyc%0d_outs", k), {10'd0, outs}, w_exp);
      tick();
    end
    idle();
    #3;
    chk("div_done_stall", stall_cnt, 16'd37);
    chk("div_done_state", {14'd0, dbg_state}, {14'd0, ST_RUN});
    tick();

    // Reset in the middle of a divide, when md_cnt has reached 10.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    tick();
    for (int k = 1; k <= 22; k++) begin
      idle();
      #3;
      if (k == 22) begin
        chk("mid_div_state", {14'd0, dbg_state}, {14'd0, ST_MD});
        chk("mid_div_stall", stall_cnt, 16'd58);
        rst = 1'b0;
      end
      tick();
    end
    #3;
    chk("abort_state", {14'd0, dbg_state}, {14'd0, ST_RST});
    chk("abort_outs",  {10'd0, outs}, {10'd0, O_RST});
    chk("abort_stall", stall_cnt, 16'd0);
    rst = 1'b1;
    tick();
    #3;
    chk("abort_rel_state", {14'd0, dbg_state}, {14'd0, ST_RUN});
    chk("abort_rel_outs",  {10'd0, outs}, {10'd0, O_RUN});

    // Continuous load-use stall drives the counter into saturation.
    drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 65540; i++) begin
      tick();
      if (i == 100)   chk("sat_ramp",  stall_cnt, 16'd100);
      if (i == 65534) chk("sat_fffe",  stall_cnt, 16'hFFFE);
      if (i == 65535) chk("sat_ffff",  stall_cnt, 16'hFFFF);
      if (i == 65540) chk("sat_hold",  stall_cnt, 16'hFFFF);
    end
    idle();
    #3;
    chk("sat_final_outs", {10'd0, outs}, {10'd0, O_RUN});

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameters: MULT_CYC, default 4, EX occupancy cycles for multiply; DIV_CYC, default 32, EX occupancy cycles for divide; both legal in 2..63.
REQ-002 SHALL have port: clk  in  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-low (rst=0 sampled at posedge resets).
REQ-004 SHALL have ports: idex_mem_read  in  1  instruction in EX is a load; idex_rt  in  5  load destination register.
REQ-005 SHALL have ports: ifid_rs  in  5, ifid_rt  in  5  source registers of instruction in ID; ifid_uses_rt  in  1  ID instruction reads rt.
REQ-006 SHALL have ports: id_md_start  in  1  ID instruction is mult/div; id_md_div  in  1  1=divide, 0=multiply.
REQ-007 SHALL have port: branch_taken  in  1  EX resolved a taken branch/jump.
REQ-008 SHALL have ports: pc_en, ifid_en, idex_en  out  1 each  write enables for PC, IF/ID and ID/EX registers.
REQ-009 SHALL have ports: ifid_flush, idex_flush  out  1 each  load bubble (all-zero control) into IF/ID, ID/EX.
REQ-010 SHALL have ports: md_busy  out  1  mult/div occupying EX; stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-011 SHALL implement FSM states RST_HOLD, RUN, MD_WAIT, and a 6-bit down-counter md_cnt.
REQ-012 Load-use hazard (hz) SHALL be: idex_mem_read & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt))).
REQ-013 RST_HOLD SHALL drive pc_en=0, ifid_en=0, idex_en=0, ifid_flush=1, idex_flush=1, md_busy=0; next state RUN unconditionally.
REQ-014 RUN with branch_taken=1 SHALL drive pc_en=1, ifid_en=1, idex_en=1, ifid_flush=1, idex_flush=1; stay RUN; hz and id_md_start ignored that cycle.
REQ-015 RUN, branch_taken=0, hz=1 SHALL drive pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, ifid_flush=0; stay RUN (one bubble per cycle hz holds); id_md_start ignored.
REQ-016 RUN, branch_taken=0, hz=0, id_md_start=0 SHALL drive all enables 1, both flushes 0; stay RUN.
REQ-017 RUN, branch_taken=0, hz=0, id_md_start=1 SHALL drive all enables 1, flushes 0 (md instr enters EX); next state MD_WAIT; md_cnt loads (id_md_div ? DIV_CYC : MULT_CYC) - 1.
REQ-018 MD_WAIT SHALL drive pc_en=0, ifid_en=0, idex_en=0, flushes 0, md_busy=1; md_cnt decrements each cycle; when md_cnt==1, next state RUN.
REQ-019 MD_WAIT SHALL ignore branch_taken, hz, id_md_start; EX occupancy totals exactly MULT_CYC/DIV_CYC cycles including entry cycle.
REQ-020 md_busy SHALL be 1 only in MD_WAIT.
REQ-021 stall_cnt SHALL increment by 1 on each posedge where pc_en=0 and state != RST_HOLD; saturate at 16'hFFFF (no wrap).
REQ-022 Outputs other than stall_cnt SHALL be combinational from state and inputs; no X on any output after first reset edge.

Reset
REQ-023 rst=0 at posedge SHALL set state=RST_HOLD, md_cnt=0, stall_cnt=0, in any state including mid-MD_WAIT (operation abandoned).
REQ-024 Reset SHALL take priority over all other inputs; first posedge with rst=1 moves RST_HOLD->RUN.

Verification
REQ-025 Reset, release, no hazards: cycle 0 after release flushes=1, enables=0; cycle 1 onward all enables=1, flushes=0, stall_cnt=0.
REQ-026 Load-use: idex_mem_read=1, idex_rt=5, ifid_rs=5 one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt=1; idex_rt=0 same stimulus -> no stall.
REQ-027 Multiply: id_md_start=1, id_md_div=0 in RUN -> md_busy=1 for exactly 3 following cycles, pc_en=0 throughout, then RUN; stall_cnt +3.
REQ-028 Divide with branch_taken and hz pulsed during MD_WAIT -> ignored; md_busy high 31 cycles, then RUN.
REQ-029 branch_taken=1 with hz=1 and id_md_start=1 simultaneously -> both flushes=1, pc_en=1, state stays RUN, stall_cnt unchanged.
REQ-030 rst=0 mid-divide (md_cnt=10) -> next cycle RST_HOLD, md_busy=0, stall_cnt=0; force stall_cnt to 16'hFFFF then stall -> holds 16'hFFFF.
